queue_controller: RTL and testbench

- Sequencing controller for the single-bank queue. It debounces the entry and exit photocells and maintains the live queue occupancy (0..7).
- It drives the wait-time ROM address from {teller count, occupancy} and registers the looked-up wait time for the display path.
- It sits between the raw sensor/switch inputs and the wait-time ROM plus the display logic.

---
 rtl/queue_controller_if.sv | 34 +++
 rtl/queue_controller.sv | 137 +++++++++++++
 tb/tb_queue_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/queue_controller_if.sv
// Queue controller bus: sensor/switch inputs, wait-time ROM port and
// occupancy/status outputs.
//   slave  : the controller (takes sensors, switches and ROM data)
//   master : the surrounding logic (drives sensors/switches, serves the ROM)
interface queue_controller_if;
  localparam int unsigned TEL_W  = 2;
  localparam int unsigned PPL_W  = 3;
  localparam int unsigned WAIT_W = 5;

  logic              sensor_front;
  logic              sensor_back;
  logic [TEL_W-1:0]  teller_sw;
  logic [TEL_W-1:0]  rom_teller;
  logic [PPL_W-1:0]  rom_people;
  logic [WAIT_W-1:0] rom_wait;
  logic [PPL_W-1:0]  people_count;
  logic [WAIT_W-1:0] wait_time;
  logic              full;
  logic              empty;
  logic              reject;
  logic              teller_err;

  modport slave (
    input  sensor_front, sensor_back, teller_sw, rom_wait,
    output rom_teller, rom_people, people_count, wait_time,
           full, empty, reject, teller_err
  );

  modport master (
    output sensor_front, sensor_back, teller_sw, rom_wait,
    input  rom_teller, rom_people, people_count, wait_time,
           full, empty, reject, teller_err
  );
endinterface

// File: rtl/queue_controller.sv
// Single-bank queue sequencing controller.
// Debounces the entry/exit photocells, tracks occupancy (0..MAX_PEOPLE),
// addresses the wait-time ROM with {teller count, occupancy} and registers
// the looked-up wait time.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - queue_controller_if.slave: sensor_front/sensor_back/teller_sw
//          (async inputs), rom_wait (ROM data in), rom_teller/rom_people
//          (ROM address), people_count, wait_time, full, empty, reject,
//          teller_err
module queue_controller #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned MAX_PEOPLE = 7,
  parameter int unsigned ERR_WAIT   = 31
) (
  input  logic               clk,
  input  logic               rst,
  queue_controller_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TEL_W  = 2;
  localparam int unsigned PPL_W  = 3;
  localparam int unsigned WAIT_W = 5;
  localparam int unsigned N_SEN  = 2;   // index 0 = front (entry), 1 = back (exit)

  typedef enum logic {S_CLEAR, S_BLOCKED} sensor_state_e;

  logic [N_SEN-1:0]  r_sen_s1;
  logic [N_SEN-1:0]  r_sen_s2;
  logic [N_SEN-1:0]  r_sen_db;
  logic [N_SEN-1:0]  r_ev;
  logic [CNT_W-1:0]  r_db_cnt [N_SEN];
  sensor_state_e     r_state  [N_SEN];
  logic [TEL_W-1:0]  r_tel_s1;
  logic [TEL_W-1:0]  r_tel_s2;
  logic [PPL_W-1:0]  r_people;
  logic [WAIT_W-1:0] r_wait;
  logic              r_reject;
  logic              r_teller_err;

  logic [N_SEN-1:0]  w_sen_raw;
  logic              w_entry_ok;
  logic              w_exit_ok;

  assign w_sen_raw  = {bus.sensor_back, bus.sensor_front};
  // Each event is judged against the current count on its own.
  assign w_entry_ok = r_ev[0] && (r_people < PPL_W'(MAX_PEOPLE));
  assign w_exit_ok  = r_ev[1] && (r_people != '0);

  // Two-flop synchronizers for all asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sen_s1 <= '0;
      r_sen_s2 <= '0;
      r_tel_s1 <= '0;
      r_tel_s2 <= '0;
    end else begin
      r_sen_s1 <= w_sen_raw;
      r_sen_s2 <= r_sen_s1;
      r_tel_s1 <= bus.teller_sw;
      r_tel_s2 <= r_tel_s1;
    end
  end

  // Per-sensor debounce and pass FSM; an event fires when the beam clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sen_db <= '0;
      r_ev     <= '0;
      for (int i = 0; i < N_SEN; i++) begin
        r_db_cnt[i] <= '0;
        r_state[i]  <= S_CLEAR;
      end
    end else begin
      for (int i = 0; i < N_SEN; i++) begin
        r_ev[i] <= 1'b0;
        // Level must differ for DEBOUNCE consecutive cycles before it is taken.
        if (r_sen_s2[i] == r_sen_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          r_sen_db[i] <= r_sen_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
        case (r_state[i])
          S_CLEAR: begin
            if (r_sen_db[i]) r_state[i] <= S_BLOCKED;
          end
          S_BLOCKED: begin
            if (!r_sen_db[i]) begin
              r_state[i] <= S_CLEAR;
              r_ev[i]    <= 1'b1;
            end
          end
          default: r_state[i] <= S_CLEAR;
        endcase
      end
    end
  end

  // Occupancy update and reject pulse, one cycle after the events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_people <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= r_ev[0] && !w_entry_ok;
      case ({w_entry_ok, w_exit_ok})
        2'b10:   r_people <= r_people + 1'b1;
        2'b01:   r_people <= r_people - 1'b1;
        default: r_people <= r_people;
      endcase
    end
  end

  // Registered wait time; an invalid teller count overrides the ROM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait       <= '0;
      r_teller_err <= 1'b0;
    end else begin
      r_teller_err <= (r_tel_s2 == '0);
      r_wait       <= (r_tel_s2 == '0) ? WAIT_W'(ERR_WAIT) : bus.rom_wait;
    end
  end

  assign bus.rom_teller   = r_tel_s2;
  assign bus.rom_people   = r_people;
  assign bus.people_count = r_people;
  assign bus.wait_time    = r_wait;
  assign bus.reject       = r_reject;
  assign bus.teller_err   = r_teller_err;
  assign bus.full         = (r_people == PPL_W'(MAX_PEOPLE));
  assign bus.empty        = (r_people == '0);
endmodule

// File: tb/tb_queue_controller.sv
// Directed self-checking bench for queue_controller with a behavioural
// wait-time ROM.
module tb_queue_controller;
  localparam int unsigned DEBOUNCE = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   rej_cnt;
  int   rej_snap;
  int   lat;
  logic [2:0] old_cnt;

  queue_controller_if bus ();

  queue_controller #(
    .DEBOUNCE   (DEBOUNCE),
    .MAX_PEOPLE (7),
    .ERR_WAIT   (31)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Wait-time ROM contents, indexed by {teller, people}.
  function automatic logic [4:0] rom_lookup(input logic [1:0] t, input logic [2:0] p);
    logic [4:0] v;
    case (t)
      2'd1:    v = 5'(3 * int'(p));
      2'd2:    v = 5'(p);
      2'd3: begin
        case (p)
          3'd0: v = 5'd0;
          3'd1: v = 5'd1;
          3'd2: v = 5'd3;
          3'd3: v = 5'd4;
          3'd4: v = 5'd5;
          3'd5: v = 5'd7;
          3'd6: v = 5'd8;
          default: v = 5'd9;
        endcase
      end
      default: v = 5'd17;
    endcase
    return v;
  endfunction

  assign bus.rom_wait = rom_lookup(bus.rom_teller, bus.rom_people);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.reject === 1'b1) rej_cnt++;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pass(input logic f, input logic b);
    bus.sensor_front = f;
    bus.sensor_back  = b;
    step(10);
    bus.sensor_front = 1'b0;
    bus.sensor_back  = 1'b0;
    step(12);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rej_cnt  = 0;
    rst = 1'b1;
    bus.sensor_front = 1'b0;
    bus.sensor_back  = 1'b0;
    bus.teller_sw    = 2'd1;
    step(2);
    chk("rst_count", 8'(bus.people_count), 8'd0);
    chk("rst_empty", 8'(bus.empty), 8'd1);
    chk("rst_full", 8'(bus.full), 8'd0);
    chk("rst_reject", 8'(bus.reject), 8'd0);
    chk("rst_wait", 8'(bus.wait_time), 8'd0);
    rst = 1'b0;
    step(4);
    chk("idle_wait", 8'(bus.wait_time), 8'd0);
    chk("idle_terr", 8'(bus.teller_err), 8'd0);

    // First entry with latency measurement from the sensor fall.
    bus.sensor_front = 1'b1;
    step(10);
    old_cnt = bus.people_count;
    bus.sensor_front = 1'b0;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (bus.people_count === old_cnt && lat < 20);
    n_checks++;
    assert (lat >= DEBOUNCE + 3 && lat <= DEBOUNCE + 5)
    else begin
      n_fail++;
      $error("FAIL entry_latency: observed %0d expected %0d+-1", lat, DEBOUNCE + 4);
    end
    step(12);
    pass(1'b1, 1'b0);
    pass(1'b1, 1'b0);
    chk("three_count", 8'(bus.people_count), 8'd3);
    chk("three_wait", 8'(bus.wait_time), 8'd9);
    chk("three_empty", 8'(bus.empty), 8'd0);

    // Glitch shorter than the debounce window.
    bus.sensor_front = 1'b1;
    step(DEBOUNCE - 1);
    bus.sensor_front = 1'b0;
    step(15);
    chk("glitch_count", 8'(bus.people_count), 8'd3);

    // Fill, then overflow with teller count 3.
    bus.teller_sw = 2'd3;
    repeat (4) pass(1'b1, 1'b0);
    chk("fill_count", 8'(bus.people_count), 8'd7);
    chk("fill_full", 8'(bus.full), 8'd1);
    chk("fill_reject", 8'(rej_cnt), 8'd0);
    rej_snap = rej_cnt;
    pass(1'b1, 1'b0);
    chk("ovf_count", 8'(bus.people_count), 8'd7);
    chk("ovf_reject", 8'(rej_cnt - rej_snap), 8'd1);
    chk("ovf_wait", 8'(bus.wait_time), 8'd9);
    rej_snap = rej_cnt;
    pass(1'b1, 1'b1);
    chk("fullsim_count", 8'(bus.people_count), 8'd6);
    chk("fullsim_reject", 8'(rej_cnt - rej_snap), 8'd1);
    chk("fullsim_wait", 8'(bus.wait_time), 8'd8);
    chk("fullsim_full", 8'(bus.full), 8'd0);

    // Drain, exit at empty, simultaneous at empty.
    repeat (6) pass(1'b0, 1'b1);
    chk("drain_count", 8'(bus.people_count), 8'd0);
    chk("drain_empty", 8'(bus.empty), 8'd1);
    rej_snap = rej_cnt;
    pass(1'b0, 1'b1);
    chk("underflow_count", 8'(bus.people_count), 8'd0);
    chk("underflow_reject", 8'(rej_cnt - rej_snap), 8'd0);
    pass(1'b1, 1'b1);
    chk("emptysim_count", 8'(bus.people_count), 8'd1);
    chk("emptysim_reject", 8'(rej_cnt - rej_snap), 8'd0);

    // Teller count 2 at occupancy 5, then invalid teller count.
    bus.teller_sw = 2'd2;
    repeat (4) pass(1'b1, 1'b0);
    chk("t2_count", 8'(bus.people_count), 8'd5);
    chk("t2_wait", 8'(bus.wait_time), 8'd5);
    chk("t2_terr", 8'(bus.teller_err), 8'd0);
    bus.teller_sw = 2'd0;
    step(3);
    chk("t0_terr", 8'(bus.teller_err), 8'd1);
    chk("t0_wait", 8'(bus.wait_time), 8'd31);
    chk("t0_count", 8'(bus.people_count), 8'd5);

    // Reset in the middle of a pass.
    bus.teller_sw = 2'd1;
    bus.sensor_front = 1'b1;
    step(10);
    rst = 1'b1;
    #1;
    chk("midrst_count", 8'(bus.people_count), 8'd0);
    chk("midrst_terr", 8'(bus.teller_err), 8'd0);
    step(2);
    bus.sensor_front = 1'b0;
    step(1);
    rst = 1'b0;
    step(15);
    chk("postrst_count", 8'(bus.people_count), 8'd0);
    chk("postrst_empty", 8'(bus.empty), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
